// File: rtl/exp6_sequenciador_jogo.sv
// exp6_sequenciador_jogo
// Control unit for the memory-sequence game. Each round it first shows the
// stored sequence on the LEDs, then collects the player's moves and checks
// them against memory. The show/timeout timer lives here; the datapath only
// supplies compare and end-of-count flags.
//
// Configuration macro: EXP6_TIMEOUT_EN
//   defined   : the ESPERA move timeout is active and FIM_TIMEOUT is reachable
//   undefined : ESPERA waits indefinitely, timeout is constant 0 and the
//               timer holds while in ESPERA
//
// Ports
//   clock, reset               rising-edge clock, async active-low reset
//   iniciar                    start/restart request (level)
//   nivel_tempo                0: TMO_LONG, 1: TMO_SHORT move timeout
//   jogada_feita               one-cycle move pulse from the datapath
//   jogada_correta             jogada register matches memory[address]
//   enderecoIgualRodada        address counter equals round counter
//   fimCR                      round counter at the last round
//   zeraC/contaC               address counter clear/increment
//   zeraCR/contaCR             round counter clear/increment
//   zeraR/registraR            jogada register clear/load
//   registraN                  load level registers
//   mostra_leds                LEDs show memory (1) or jogada (0)
//   acertou/errou/timeout      result flags, held in the final states
//   pronto                     high in every FIM_* state
//   db_estado                  current state code
//
// state          | meaning
// 0 INICIAL      | idle, waiting for iniciar
// 1 PREPARA      | clear counters, load level
// 2 INICIA_RODADA| clear address, clear timer
// 3 MOSTRA_ON    | light memory[address] for SHOW_ON cycles
// 4 MOSTRA_OFF   | dark gap for SHOW_OFF cycles
// 5 PROX_MOSTRA  | advance address to next shown entry
// 6 ZERA_END     | rewind address, clear jogada register
// 7 ESPERA       | wait for a move (timeout when enabled)
// 8 REGISTRA     | load jogada register
// 9 COMPARA      | compare jogada with memory
// A PROX_JOGADA  | advance address, restart timeout
// B PROX_RODADA  | advance round
// C FIM_ACERTOU  | game won
// D FIM_ERROU    | wrong move
// E FIM_TIMEOUT  | move timed out

module exp6_sequenciador_jogo #(
    parameter int TIMER_W   = 16,
    parameter int SHOW_ON   = 1000,
    parameter int SHOW_OFF  = 500,
    parameter int TMO_LONG  = 5000,
    parameter int TMO_SHORT = 3000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       nivel_tempo,
    input  logic       jogada_feita,
    input  logic       jogada_correta,
    input  logic       enderecoIgualRodada,
    input  logic       fimCR,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraCR,
    output logic       contaCR,
    output logic       zeraR,
    output logic       registraR,
    output logic       registraN,
    output logic       mostra_leds,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        INICIA_RODADA = 4'h2,
        MOSTRA_ON     = 4'h3,
        MOSTRA_OFF    = 4'h4,
        PROX_MOSTRA   = 4'h5,
        ZERA_END      = 4'h6,
        ESPERA        = 4'h7,
        REGISTRA      = 4'h8,
        COMPARA       = 4'h9,
        PROX_JOGADA   = 4'hA,
        PROX_RODADA   = 4'hB,
        FIM_ACERTOU   = 4'hC,
        FIM_ERROU     = 4'hD,
        FIM_TIMEOUT   = 4'hE
    } state_t;

    localparam logic [TIMER_W-1:0] SHOW_ON_M1  = TIMER_W'(SHOW_ON - 1);
    localparam logic [TIMER_W-1:0] SHOW_OFF_M1 = TIMER_W'(SHOW_OFF - 1);

    state_t             state;
    state_t             state_next;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_next;
    logic               tmr_run;
    logic               tmr_hold;
    logic [11:0]        outs_next;

`ifdef EXP6_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] TMO_LONG_M1  = TIMER_W'(TMO_LONG - 1);
    localparam logic [TIMER_W-1:0] TMO_SHORT_M1 = TIMER_W'(TMO_SHORT - 1);
    logic [TIMER_W-1:0] tmo_limit_m1;
    assign tmo_limit_m1 = nivel_tempo ? TMO_SHORT_M1 : TMO_LONG_M1;
`else
    logic unused_nivel_tempo;
    assign unused_nivel_tempo = nivel_tempo;
`endif

    always_comb begin
        state_next = state;
        tmr_run    = 1'b0;
        tmr_hold   = 1'b0;
        timer_next = '0;
        case (state)
            INICIAL:       if (iniciar) state_next = PREPARA;
            PREPARA:       state_next = INICIA_RODADA;
            INICIA_RODADA: state_next = MOSTRA_ON;
            MOSTRA_ON: begin
                tmr_run = 1'b1;
                if (timer == SHOW_ON_M1) state_next = MOSTRA_OFF;
            end
            MOSTRA_OFF: begin
                tmr_run = 1'b1;
                if (timer == SHOW_OFF_M1)
                    state_next = enderecoIgualRodada ? ZERA_END : PROX_MOSTRA;
            end
            PROX_MOSTRA:   state_next = MOSTRA_ON;
            ZERA_END:      state_next = ESPERA;
            ESPERA: begin
`ifdef EXP6_TIMEOUT_EN
                tmr_run = 1'b1;
                // a move arriving on the limit cycle still counts
                if (jogada_feita)                state_next = REGISTRA;
                else if (timer == tmo_limit_m1)  state_next = FIM_TIMEOUT;
`else
                tmr_hold = 1'b1;
                if (jogada_feita) state_next = REGISTRA;
`endif
            end
            REGISTRA:      state_next = COMPARA;
            COMPARA: begin
                if (!jogada_correta)          state_next = FIM_ERROU;
                else if (!enderecoIgualRodada) state_next = PROX_JOGADA;
                else if (fimCR)                state_next = FIM_ACERTOU;
                else                           state_next = PROX_RODADA;
            end
            PROX_JOGADA:   state_next = ESPERA;
            PROX_RODADA:   state_next = INICIA_RODADA;
            FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                           if (iniciar) state_next = PREPARA;
            default:       state_next = INICIAL;
        endcase

        // timing states count while staying and clear on exit; all other
        // states leave the timer at zero so the next timing state starts fresh
        if (tmr_run && (state_next == state))
            timer_next = (timer == '1) ? timer : timer + 1'b1;
        else if (tmr_hold)
            timer_next = timer;
    end

    // Outputs are decoded from the next state and registered, so they line up
    // with the state register exactly (a Moore decode without output glitches).
    // Bit order: zeraC contaC zeraCR contaCR zeraR registraR registraN
    //            mostra_leds acertou errou timeout pronto
    always_comb begin
        outs_next = '0;
        case (state_next)
            PREPARA:       outs_next = 12'b1010_1010_0000;
            INICIA_RODADA: outs_next = 12'b1000_0000_0000;
            MOSTRA_ON:     outs_next = 12'b0000_0001_0000;
            PROX_MOSTRA:   outs_next = 12'b0100_0000_0000;
            ZERA_END:      outs_next = 12'b1000_1000_0000;
            REGISTRA:      outs_next = 12'b0000_0100_0000;
            PROX_JOGADA:   outs_next = 12'b0100_0000_0000;
            PROX_RODADA:   outs_next = 12'b0001_0000_0000;
            FIM_ACERTOU:   outs_next = 12'b0000_0000_1001;
            FIM_ERROU:     outs_next = 12'b0000_0000_0101;
`ifdef EXP6_TIMEOUT_EN
            FIM_TIMEOUT:   outs_next = 12'b0000_0000_0011;
`else
            FIM_TIMEOUT:   outs_next = 12'b0000_0000_0001;
`endif
            default:       outs_next = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= INICIAL;
            timer <= '0;
            {zeraC, contaC, zeraCR, contaCR, zeraR, registraR, registraN,
             mostra_leds, acertou, errou, timeout, pronto} <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            {zeraC, contaC, zeraCR, contaCR, zeraR, registraR, registraN,
             mostra_leds, acertou, errou, timeout, pronto} <= outs_next;
        end
    end

    assign db_estado = state;

endmodule

// File: tb/tb_exp6_sequenciador_jogo.sv
module tb_exp6_sequenciador_jogo;

    localparam int TW   = 8;
    localparam int SON  = 4;
    localparam int SOFF = 3;
    localparam int TL   = 20;
    localparam int TS   = 12;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic iniciar = 1'b0, nivel_tempo = 1'b0, jogada_feita = 1'b0;
    logic jogada_correta = 1'b0, endereco_igual = 1'b0, fim_cr = 1'b0;
    logic zeraC, contaC, zeraCR, contaCR, zeraR, registraR, registraN;
    logic mostra_leds, acertou, errou, timeout, pronto;
    logic [3:0] db_estado;
    logic [11:0] outs;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic ini, jf, jc, eir, fim;
        logic [3:0] st;
    } step_t;

    step_t      seq[$];
    logic [3:0] exp_q[$];
    logic [3:0] exp_st;

    exp6_sequenciador_jogo #(
        .TIMER_W(TW), .SHOW_ON(SON), .SHOW_OFF(SOFF),
        .TMO_LONG(TL), .TMO_SHORT(TS)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .nivel_tempo(nivel_tempo), .jogada_feita(jogada_feita),
        .jogada_correta(jogada_correta),
        .enderecoIgualRodada(endereco_igual), .fimCR(fim_cr),
        .zeraC(zeraC), .contaC(contaC), .zeraCR(zeraCR), .contaCR(contaCR),
        .zeraR(zeraR), .registraR(registraR), .registraN(registraN),
        .mostra_leds(mostra_leds), .acertou(acertou), .errou(errou),
        .timeout(timeout), .pronto(pronto), .db_estado(db_estado)
    );

    assign outs = {zeraC, contaC, zeraCR, contaCR, zeraR, registraR, registraN,
                   mostra_leds, acertou, errou, timeout, pronto};

    always #5 clock = ~clock;

    // Expected output pattern for each state, same bit order as outs.
    function automatic logic [11:0] exp_outs(input logic [3:0] st);
        case (st)
            4'h1: return 12'b1010_1010_0000;
            4'h2: return 12'b1000_0000_0000;
            4'h3: return 12'b0000_0001_0000;
            4'h5: return 12'b0100_0000_0000;
            4'h6: return 12'b1000_1000_0000;
            4'h8: return 12'b0000_0100_0000;
            4'hA: return 12'b0100_0000_0000;
            4'hB: return 12'b0001_0000_0000;
            4'hC: return 12'b0000_0000_1001;
            4'hD: return 12'b0000_0000_0101;
`ifdef EXP6_TIMEOUT_EN
            4'hE: return 12'b0000_0000_0011;
`else
            4'hE: return 12'b0000_0000_0001;
`endif
            default: return 12'b0;
        endcase
    endfunction

    // Append n cycles; inputs are those applied before the edge that should
    // land the FSM in st.
    function automatic void add(input logic [3:0] st, input int n = 1,
                                input logic ini = 1'b0, input logic jf = 1'b0,
                                input logic jc = 1'b0, input logic eir = 1'b0,
                                input logic fim = 1'b0);
        for (int i = 0; i < n; i++) seq.push_back('{ini, jf, jc, eir, fim, st});
    endfunction

    // From INICIAL or FIM_*: start, show a single entry, land in ESPERA.
    function automatic void add_start_round0();
        add(4'h1, 1, 1'b1);
        add(4'h2);
        add(4'h3, SON);
        add(4'h4, SOFF);
        add(4'h6, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(4'h7);
    endfunction

    task automatic do_reset();
        @(negedge clock) reset = 1'b0;
        @(negedge clock) reset = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (db_estado !== 4'h0 || outs !== 12'b0) begin
            fails++;
            $display("FAIL reset_async: state=%h outs=%b, expected state=0 outs=0", db_estado, outs);
        end
        @(negedge clock) reset = 1'b1;
        seq.delete();
        add(4'h0, 4);
        foreach (seq[i]) begin
            iniciar = seq[i].ini; jogada_feita = seq[i].jf; jogada_correta = seq[i].jc;
            endereco_igual = seq[i].eir; fim_cr = seq[i].fim;
            exp_q.push_back(seq[i].st);
            @(posedge clock); #1;
            exp_st = exp_q.pop_front();
            tests++;
            if (db_estado !== exp_st || outs !== exp_outs(exp_st)) begin
                fails++;
                $display("FAIL reset_idle step %0d: state=%h outs=%b, expected state=%h outs=%b",
                         i, db_estado, outs, exp_st, exp_outs(exp_st));
            end
        end
    endtask

    task automatic test_round0_win();
        seq.delete();
        add_start_round0();
        add(4'h7);
        add(4'h8, 1, 1'b0, 1'b1);
        add(4'h9);
        add(4'hC, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        add(4'hC, 2);
        foreach (seq[i]) begin
            iniciar = seq[i].ini; jogada_feita = seq[i].jf; jogada_correta = seq[i].jc;
            endereco_igual = seq[i].eir; fim_cr = seq[i].fim;
            exp_q.push_back(seq[i].st);
            @(posedge clock); #1;
            exp_st = exp_q.pop_front();
            tests++;
            if (db_estado !== exp_st || outs !== exp_outs(exp_st)) begin
                fails++;
                $display("FAIL round0_win step %0d: state=%h outs=%b, expected state=%h outs=%b",
                         i, db_estado, outs, exp_st, exp_outs(exp_st));
            end
        end
    endtask

    // Starts in FIM_ACERTOU; second round shows two entries and takes two
    // moves, ending a few cycles into the next round's MOSTRA_ON.
    task automatic test_round2();
        seq.delete();
        add(4'h1, 1, 1'b1);
        add(4'h2);
        add(4'h3, SON);
        add(4'h4, SOFF);
        add(4'h5);
        add(4'h3, 1, 1'b0, 1'b1);          // move pulse outside ESPERA ignored
        add(4'h3, SON - 1);
        add(4'h4, SOFF);
        add(4'h6, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(4'h7);
        add(4'h8, 1, 1'b0, 1'b1);
        add(4'h9);
        add(4'hA, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(4'h7, 1, 1'b0, 1'b1);          // ignored in PROX_JOGADA
        add(4'h7);
        add(4'h8, 1, 1'b0, 1'b1);
        add(4'h9);
        add(4'hB, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(4'h2);
        add(4'h3, 2);
        foreach (seq[i]) begin
            iniciar = seq[i].ini; jogada_feita = seq[i].jf; jogada_correta = seq[i].jc;
            endereco_igual = seq[i].eir; fim_cr = seq[i].fim;
            exp_q.push_back(seq[i].st);
            @(posedge clock); #1;
            exp_st = exp_q.pop_front();
            tests++;
            if (db_estado !== exp_st || outs !== exp_outs(exp_st)) begin
                fails++;
                $display("FAIL round2 step %0d: state=%h outs=%b, expected state=%h outs=%b",
                         i, db_estado, outs, exp_st, exp_outs(exp_st));
            end
        end
    endtask

    // Entered while in MOSTRA_ON.
    task automatic test_reset_mid();
        #2 reset = 1'b0;
        #1;
        tests++;
        if (db_estado !== 4'h0 || outs !== 12'b0) begin
            fails++;
            $display("FAIL reset_mid: state=%h outs=%b, expected state=0 outs=0", db_estado, outs);
        end
        @(negedge clock) reset = 1'b1;
        seq.delete();
        add(4'h0, 5);
        foreach (seq[i]) begin
            iniciar = seq[i].ini; jogada_feita = seq[i].jf; jogada_correta = seq[i].jc;
            endereco_igual = seq[i].eir; fim_cr = seq[i].fim;
            exp_q.push_back(seq[i].st);
            @(posedge clock); #1;
            exp_st = exp_q.pop_front();
            tests++;
            if (db_estado !== exp_st || outs !== exp_outs(exp_st)) begin
                fails++;
                $display("FAIL reset_mid_idle step %0d: state=%h outs=%b, expected state=%h outs=%b",
                         i, db_estado, outs, exp_st, exp_outs(exp_st));
            end
        end
    endtask

    task automatic test_wrong();
        seq.delete();
        add_start_round0();
        add(4'h8, 1, 1'b0, 1'b1);
        add(4'h9);
        add(4'hD, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(4'hD, 2);
        add(4'h1, 1, 1'b1);
        add(4'h2);
        foreach (seq[i]) begin
            iniciar = seq[i].ini; jogada_feita = seq[i].jf; jogada_correta = seq[i].jc;
            endereco_igual = seq[i].eir; fim_cr = seq[i].fim;
            exp_q.push_back(seq[i].st);
            @(posedge clock); #1;
            exp_st = exp_q.pop_front();
            tests++;
            if (db_estado !== exp_st || outs !== exp_outs(exp_st)) begin
                fails++;
                $display("FAIL wrong step %0d: state=%h outs=%b, expected state=%h outs=%b",
                         i, db_estado, outs, exp_st, exp_outs(exp_st));
            end
        end
    endtask

    task automatic test_timeout();
        seq.delete();
`ifdef EXP6_TIMEOUT_EN
        nivel_tempo = 1'b1;
        add_start_round0();
        add(4'h7, TS - 1);                 // ESPERA lasts exactly TS cycles
        add(4'hE);
        add(4'hE, 2);
        add_start_round0();
        add(4'h7, TS - 1);
        add(4'h8, 1, 1'b0, 1'b1);          // move on the limit cycle wins
        add(4'h9);
        add(4'hC, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
`else
        nivel_tempo = 1'b0;
        add_start_round0();
        add(4'h7, 2 * TL);
        add(4'h8, 1, 1'b0, 1'b1);
        add(4'h9);
        add(4'hC, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
`endif
        foreach (seq[i]) begin
            iniciar = seq[i].ini; jogada_feita = seq[i].jf; jogada_correta = seq[i].jc;
            endereco_igual = seq[i].eir; fim_cr = seq[i].fim;
            exp_q.push_back(seq[i].st);
            @(posedge clock); #1;
            exp_st = exp_q.pop_front();
            tests++;
            if (db_estado !== exp_st || outs !== exp_outs(exp_st)) begin
                fails++;
                $display("FAIL timeout step %0d: state=%h outs=%b, expected state=%h outs=%b",
                         i, db_estado, outs, exp_st, exp_outs(exp_st));
            end
        end
    endtask

    initial begin
        test_reset();
        test_round0_win();
        test_round2();
        test_reset_mid();
        test_wrong();
        do_reset();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
